pri_enc_rr: RTL and testbench



---
 rtl/pri_enc_rr_pkg.sv | 14 +
 rtl/pri_enc_rr_find_first.sv | 49 ++++
 rtl/pri_enc_rr.sv | 75 +++++++
 tb/tb_pri_enc_rr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pri_enc_rr_pkg.sv
// Shared LLC arbitration package: sizing helpers for request/index vectors.
package pri_enc_rr_pkg;

  // Bits needed to encode n distinct values (minimum 1).
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pri_enc_rr_find_first.sv
// Combinational rotating find-first: first set bit of vec at or after base, wrapping to 0.
module rr_find_first
  import pri_enc_rr_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG_WIDTH = 3
) (
  input  logic [WIDTH-1:0]     vec,
  input  logic [LOG_WIDTH-1:0] base,
  output logic [LOG_WIDTH-1:0] idx,
  output logic                 found
);

  localparam int unsigned ScanW = clog2_f(2 * WIDTH);

  logic [WIDTH-1:0]   thermo;
  logic [2*WIDTH-1:0] scan;
  logic [ScanW-1:0]   pos;

  // Thermometer of positions at or above the base pointer.
  always_comb begin
    thermo = '0;
    for (int i = 0; i < WIDTH; i++) begin
      thermo[i] = (i >= int'(base));
    end
  end

  // Lower half holds only bits >= base, so they win; the upper copy supplies the wrapped bits.
  assign scan  = {vec, vec & thermo};
  assign found = |vec;

  // Lowest set position of the doubled vector (downward loop leaves the lowest hit).
  always_comb begin
    pos = '0;
    for (int i = 2 * WIDTH - 1; i >= 0; i--) begin
      if (scan[i]) pos = ScanW'(i);
    end
  end

  // Fold the doubled position back into 0..WIDTH-1.
  always_comb begin
    if (pos >= ScanW'(WIDTH)) begin
      idx = LOG_WIDTH'(pos - ScanW'(WIDTH));
    end else begin
      idx = LOG_WIDTH'(pos);
    end
  end

endmodule

// File: rtl/pri_enc_rr.sv
// Registered round-robin priority encoder with a valid/ready result stage.
module pri_enc_rr
  import pri_enc_rr_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG_WIDTH = 3,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic [WIDTH-1:0]     mask,
  input  logic                 ptr_clr,
  output logic [LOG_WIDTH-1:0] out,
  output logic [WIDTH-1:0]     out_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG_WIDTH-1:0] ptr
);

  logic [WIDTH-1:0]     elig;
  logic [LOG_WIDTH-1:0] sel_idx;
  logic                 found;
  logic                 load;
  logic                 hs;
  logic [LOG_WIDTH-1:0] ptr_d;

  assign elig = in & ~mask;
  // out_ready only gates register enables; nothing reaches the outputs combinationally.
  assign load = !out_valid || out_ready;
  assign hs   = out_valid && out_ready;

  rr_find_first #(
    .WIDTH    (WIDTH),
    .LOG_WIDTH(LOG_WIDTH)
  ) u_find (
    .vec  (elig),
    .base (ptr),
    .idx  (sel_idx),
    .found(found)
  );

  // Result register: reload when empty or being consumed, otherwise hold the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= '0;
      out_onehot <= '0;
    end else if (load) begin
      out_valid  <= found;
      out        <= found ? sel_idx : '0;
      out_onehot <= found ? (WIDTH'(1) << sel_idx) : '0;
    end
  end

  // Pointer next state: clear wins, then advance past the accepted index with explicit wrap.
  always_comb begin
    ptr_d = ptr;
    if (ptr_clr || !RR_EN) begin
      ptr_d = '0;
    end else if (hs) begin
      ptr_d = (out == LOG_WIDTH'(WIDTH - 1)) ? '0 : out + LOG_WIDTH'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_d;
    end
  end

endmodule

// File: tb/tb_pri_enc_rr.sv
// Bench for pri_enc_rr: round-robin and fixed-priority builds driven by the same stimulus.
module tb_pri_enc_rr;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] msk;
  logic       ptr_clr;
  logic       out_ready;

  logic [2:0] out_r, ptr_r, out_f, ptr_f;
  logic [7:0] oh_r, oh_f;
  logic       v_r, v_f;

  int checks   = 0;
  int failures = 0;

  pri_enc_rr #(.WIDTH(8), .LOG_WIDTH(3), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in(req), .mask(msk), .ptr_clr(ptr_clr),
    .out(out_r), .out_onehot(oh_r), .out_valid(v_r), .out_ready(out_ready), .ptr(ptr_r)
  );

  pri_enc_rr #(.WIDTH(8), .LOG_WIDTH(3), .RR_EN(1'b0)) dut_fix (
    .clk(clk), .rst(rst), .in(req), .mask(msk), .ptr_clr(ptr_clr),
    .out(out_f), .out_onehot(oh_f), .out_valid(v_f), .out_ready(out_ready), .ptr(ptr_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: index 0 = round-robin build, index 1 = fixed-priority build.
  int m_out[2];
  int m_ptr[2];
  bit m_valid[2];
  int mp;

  // First eligible index scanning base, base+1, ... modulo W; -1 if none.
  function automatic int pick(input logic [7:0] e, input int base);
    for (int k = 0; k < W; k++) begin
      if (e[(base + k) % W]) return (base + k) % W;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_out[i]   <= 0;
        m_ptr[i]   <= 0;
        m_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mp = pick(req & ~msk, m_ptr[i]);
        if (!m_valid[i] || out_ready) begin
          m_valid[i] <= (mp >= 0);
          m_out[i]   <= (mp >= 0) ? mp : 0;
        end
        if (ptr_clr || i == 1) m_ptr[i] <= 0;
        else if (m_valid[i] && out_ready) m_ptr[i] <= (m_out[i] + 1) % W;
      end
    end
  end

  // Every-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rr_valid", 32'(v_r), 32'(m_valid[0]));
      chk("rr_out", 32'(out_r), m_out[0]);
      chk("rr_onehot", 32'(oh_r), m_valid[0] ? (32'd1 << m_out[0]) : 32'd0);
      chk("rr_ptr", 32'(ptr_r), m_ptr[0]);
      chk("fx_valid", 32'(v_f), 32'(m_valid[1]));
      chk("fx_out", 32'(out_f), m_out[1]);
      chk("fx_onehot", 32'(oh_f), m_valid[1] ? (32'd1 << m_out[1]) : 32'd0);
      chk("fx_ptr", 32'(ptr_f), m_ptr[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_rr(input string name, input int o, input int p, input bit v);
    chk({name, "_out"}, 32'(out_r), o);
    chk({name, "_ptr"}, 32'(ptr_r), p);
    chk({name, "_valid"}, 32'(v_r), 32'(v));
  endtask

  int exp_o1[10] = '{1, 1, 4, 4, 7, 7, 1, 1, 4, 4};
  int exp_p1[10] = '{0, 2, 2, 5, 5, 0, 0, 2, 2, 5};

  initial begin
    rst = 1'b1; req = '0; msk = '0; ptr_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rr("reset", 0, 0, 1'b0);
    chk("reset_onehot", 32'(oh_r), 0);
    rst = 1'b0;

    // Rotation over bits 1,4,7; each index is granted twice since the search uses the old ptr.
    req = 8'b1001_0010; out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk_rr($sformatf("rot%0d", n), exp_o1[n], exp_p1[n], 1'b1);
    end

    // Stall holds the result.
    do_reset();
    req = 8'hFF; out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_rr($sformatf("stall%0d", n), 0, 0, 1'b1);
      chk("stall_onehot", 32'(oh_r), 32'h01);
    end
    out_ready = 1'b1;
    tick();
    chk_rr("stall_acc", 0, 1, 1'b1);
    tick();
    chk_rr("stall_next", 1, 1, 1'b1);
    chk("stall_next_oh", 32'(oh_r), 32'h02);

    // Wrap from ptr 7 to low bits.
    do_reset();
    req = 8'h40; out_ready = 1'b1;
    tick();
    chk_rr("wrapa0", 6, 0, 1'b1);
    tick();
    chk_rr("wrapa1", 6, 7, 1'b1);
    req = 8'h03;
    tick();
    chk_rr("wrapa2", 0, 7, 1'b1);
    tick();
    chk_rr("wrapa3", 0, 1, 1'b1);

    // Grant of top index wraps ptr to 0.
    do_reset();
    req = 8'h40; out_ready = 1'b1;
    tick();
    tick();
    chk_rr("wrapb1", 6, 7, 1'b1);
    req = 8'h80;
    tick();
    chk_rr("wrapb2", 7, 7, 1'b1);
    tick();
    chk_rr("wrapb3", 7, 0, 1'b1);

    // Mask and empty eligible vector.
    do_reset();
    req = 8'h0C; msk = 8'h04; out_ready = 1'b1;
    tick();
    chk_rr("mask", 3, 0, 1'b1);
    chk("mask_onehot", 32'(oh_r), 32'h08);
    msk = 8'h0C;
    tick();
    chk_rr("empty0", 0, 4, 1'b0);
    tick();
    chk_rr("empty1", 0, 4, 1'b0);
    chk("empty_onehot", 32'(oh_r), 0);

    // ptr_clr beats the handshake advance.
    do_reset();
    msk = 8'h00; req = 8'h20; out_ready = 1'b0;
    tick();
    chk_rr("clr0", 5, 0, 1'b1);
    out_ready = 1'b1; ptr_clr = 1'b1;
    tick();
    chk_rr("clr1", 5, 0, 1'b1);
    ptr_clr = 1'b0;

    // Fixed-priority build keeps granting the lowest index.
    req = 8'hA0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("fix_out", 32'(out_f), 5);
      chk("fix_ptr", 32'(ptr_f), 0);
      chk("fix_valid", 32'(v_f), 1);
    end

    // Asynchronous reset mid-handshake.
    do_reset();
    req = 8'h40; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    chk_rr("pre_arst", 6, 7, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_rr("arst", 0, 0, 1'b0);
    chk("arst_onehot", 32'(oh_r), 0);
    rst = 1'b0;
    req = 8'h10; out_ready = 1'b1;
    tick();
    chk_rr("post_arst", 4, 0, 1'b1);
    chk("post_arst_oh", 32'(oh_r), 32'h10);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
